// File: rtl/shift_rotate_sequencer.sv
// Iterative shift/rotate unit: applies a 32-bit SHL/SHR/SHRA/ROL/ROR request
// at most STEP bit positions per clock, with a start/busy/done handshake.
module shift_rotate_sequencer #(
    parameter int unsigned STEP = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_SHL  = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHRA = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4
    } op_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      state, state_n;
    op_t         op_q, op_n;
    logic [31:0] w, w_n;
    logic [4:0]  rem, rem_n;
    logic [31:0] result_n;
    logic [4:0]  step_n;
    logic [31:0] stepped;
    logic        unused_b_hi;

    // Only the low five bits of the amount matter (amount mod 32).
    assign unused_b_hi = ^B[31:5];

    assign step_n = (rem < STEP_AMT) ? rem : STEP_AMT;

    // One partial step; step_n is never zero while in RUN, so the rotate
    // complement shift stays within 1..31.
    always_comb begin
        stepped = w;
        case (op_q)
            OP_SHL:  stepped = w << step_n;
            OP_SHR:  stepped = w >> step_n;
            OP_SHRA: stepped = $unsigned($signed(w) >>> step_n);
            OP_ROL:  stepped = (w << step_n) | (w >> (6'd32 - {1'b0, step_n}));
            OP_ROR:  stepped = (w >> step_n) | (w << (6'd32 - {1'b0, step_n}));
            default: stepped = w;
        endcase
    end

    always_comb begin
        state_n  = state;
        op_n     = op_q;
        w_n      = w;
        rem_n    = rem;
        result_n = result;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    w_n   = A;
                    op_n  = op_t'(op);
                    rem_n = B[4:0];
                    if (B[4:0] == 5'd0 || op > 3'd4) begin
                        state_n  = DONE;
                        result_n = A;
                    end else begin
                        state_n = RUN;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                w_n   = stepped;
                rem_n = rem - step_n;
                if (rem == step_n) begin
                    state_n  = DONE;
                    result_n = stepped;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state  <= IDLE;
            op_q   <= OP_SHL;
            w      <= '0;
            rem    <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            w      <= w_n;
            rem    <= rem_n;
            result <= result_n;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Self-checking bench for shift_rotate_sequencer (STEP=4): directed test plan
// plus randomized requests against an arithmetic reference model.
module tb_shift_rotate_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int unsigned checks;
    int unsigned fails;
    logic [31:0] held;

    shift_rotate_sequencer #(.STEP(4)) dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int unsigned amt;
        logic [63:0] dbl;
        amt = b[4:0];
        dbl = {a, a};
        case (o)
            3'd0: return a << amt;
            3'd1: return a >> amt;
            3'd2: return $unsigned($signed(a) >>> amt);
            3'd3: begin dbl = dbl << amt; return dbl[63:32]; end
            3'd4: begin dbl = dbl >> amt; return dbl[31:0]; end
            default: return a;
        endcase
    endfunction

    function automatic int unsigned model_latency(input logic [2:0] o, input logic [31:0] b);
        int unsigned amt;
        amt = b[4:0];
        if (o > 3'd4 || amt == 0) return 1;
        return 1 + (amt + 3) / 4;
    endfunction

    // Call at a negedge; drives the request, then checks handshake and result
    // cycle by cycle until the done cycle (returns at that negedge).
    // glitch=1 issues a competing start while busy, which must be ignored.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit glitch);
        logic [31:0] exp;
        int unsigned lat;
        exp = model_result(o, a, b);
        lat = model_latency(o, b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        for (int unsigned i = 1; i <= lat; i++) begin
            @(negedge clock);
            check($sformatf("busy op%0d c%0d", o, i), {31'b0, busy}, {31'b0, (i < lat)});
            check($sformatf("done op%0d c%0d", o, i), {31'b0, done}, {31'b0, (i == lat)});
            if (i < lat)
                check($sformatf("held op%0d c%0d", o, i), result, held);
            else
                check($sformatf("result op%0d a%h b%0d", o, a, b[4:0]), result, exp);
            if (glitch && i + 1 < lat) begin
                start = 1'b1;
                op    = 3'd0;
                A     = 32'hFFFF_FFFF;
                B     = 32'd5;
            end else begin
                start = 1'b0;
                op    = 3'($urandom_range(7));
                A     = $urandom;
                B     = $urandom;
            end
        end
        held = exp;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        held   = '0;
        clear  = 1'b0;
        start  = 1'b0;
        op     = '0;
        A      = '0;
        B      = '0;

        repeat (2) @(negedge clock);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        clear = 1'b1;
        @(negedge clock);

        issue(3'd3, 32'h8000_0001, 32'd1, 1'b0);
        @(negedge clock);
        issue(3'd4, 32'h1234_5678, 32'd8, 1'b0);
        @(negedge clock);
        issue(3'd0, 32'h0000_FFFF, 32'd20, 1'b0);
        @(negedge clock);
        issue(3'd2, 32'h8000_0000, 32'd31, 1'b0);
        issue(3'd1, 32'h8000_0000, 32'd31, 1'b0);
        @(negedge clock);
        issue(3'd3, 32'hDEAD_BEEF, 32'h20, 1'b0);
        @(negedge clock);
        issue(3'd7, 32'h5, 32'd3, 1'b0);
        @(negedge clock);
        issue(3'd4, 32'h1, 32'd16, 1'b1);
        check("ignored start", result, 32'h0001_0000);
        issue(3'd3, 32'h1, 32'd4, 1'b0);
        check("back-to-back", result, 32'h0000_0010);

        // Reset in the middle of a RUN drops the request without a done pulse.
        @(negedge clock);
        start = 1'b1; op = 3'd2; A = 32'h8000_0000; B = 32'd31;
        @(negedge clock);
        start = 1'b0;
        check("pre-clear busy", {31'b0, busy}, 32'd1);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("clear busy", {31'b0, busy}, 32'd0);
        check("clear done", {31'b0, done}, 32'd0);
        check("clear result", result, 32'd0);
        clear = 1'b1;
        held  = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clock);
            check("no stale done", {31'b0, done}, 32'd0);
        end

        // clear wins over start on the same edge.
        clear = 1'b0; start = 1'b1; op = 3'd0; A = 32'h1; B = 32'd1;
        @(negedge clock);
        check("clear over start", {31'b0, busy | done}, 32'd0);
        clear = 1'b1; start = 1'b0;
        @(negedge clock);

        for (int unsigned n = 0; n < 40; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7) == 0) rb[4:0] = 5'd0;
            issue(ro, ra, rb, ($urandom_range(5) == 0));
            if ($urandom_range(1) == 0) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
